// File: rtl/matrix_op_dispatcher.sv
// Routes one matrix command at a time to one of NUM_UNITS op units, muxing the shared storage
// read port and writer interface to the selected unit. Optional watchdog: MATRIX_OP_DISPATCHER_WATCHDOG_EN.
`ifndef MATRIX_ADDR_WIDTH
`define MATRIX_ADDR_WIDTH 12
`endif
`ifndef MATRIX_DATA_WIDTH
`define MATRIX_DATA_WIDTH 32
`endif

module matrix_op_dispatcher #(
    parameter int NUM_UNITS      = 4,
    parameter int ADDR_WIDTH     = `MATRIX_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `MATRIX_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [2:0]                            cmd_op,
    input  logic [2:0]                            cmd_a_id,
    input  logic [2:0]                            cmd_b_id,
    output logic [NUM_UNITS-1:0]                  unit_start,
    output logic [2:0]                            unit_a_id,
    output logic [2:0]                            unit_b_id,
    input  logic [NUM_UNITS-1:0]                  unit_busy,
    input  logic [NUM_UNITS-1:0][2:0]             unit_status,
    input  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0]  unit_read_addr,
    output logic [ADDR_WIDTH-1:0]                 read_addr,
    input  logic [NUM_UNITS-1:0]                  unit_write_request,
    input  logic [NUM_UNITS-1:0]                  unit_data_valid,
    input  logic [NUM_UNITS-1:0][2:0]             unit_matrix_id,
    input  logic [NUM_UNITS-1:0][7:0]             unit_actual_rows,
    input  logic [NUM_UNITS-1:0][7:0]             unit_actual_cols,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  unit_data_in,
    input  logic [NUM_UNITS-1:0][63:0]            unit_matrix_name,
    output logic                                  write_request,
    output logic                                  data_valid,
    output logic [2:0]                            matrix_id,
    output logic [7:0]                            actual_rows,
    output logic [7:0]                            actual_cols,
    output logic [DATA_WIDTH-1:0]                 data_in,
    output logic [63:0]                           matrix_name,
    input  logic                                  write_ready,
    input  logic                                  writer_ready,
    input  logic                                  write_done,
    output logic [NUM_UNITS-1:0]                  unit_write_ready,
    output logic [NUM_UNITS-1:0]                  unit_writer_ready,
    output logic [NUM_UNITS-1:0]                  unit_write_done,
    output logic                                  busy,
    output logic                                  done,
    output logic [2:0]                            status
);

    // matrix_op_status_e encoding
    localparam logic [2:0] MATRIX_OP_STATUS_IDLE         = 3'd0;
    localparam logic [2:0] MATRIX_OP_STATUS_BUSY         = 3'd1;
    localparam logic [2:0] MATRIX_OP_STATUS_SUCCESS      = 3'd2;
    localparam logic [2:0] MATRIX_OP_STATUS_ERR_FORMAT   = 3'd3;
    localparam logic [2:0] MATRIX_OP_STATUS_ERR_INTERNAL = 3'd4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_COMPLETE  = 3'd4;

    localparam int SW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [2:0]    state;
    logic [SW-1:0] sel;
    logic          active;
    logic          cmd_fire;
    logic          op_bad;
    logic          wd_expired;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_COMPLETE);
    assign active    = (state == S_LAUNCH) || (state == S_WAIT_BUSY) || (state == S_RUN);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign op_bad    = 32'(cmd_op) >= NUM_UNITS;

`ifdef MATRIX_OP_DISPATCHER_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == S_LAUNCH)
            wd_cnt <= '0;
        else if ((state == S_WAIT_BUSY) || (state == S_RUN))
            wd_cnt <= wd_cnt + WDW'(1);
    end

    // Fires so that done lands exactly TIMEOUT_CYCLES cycles after the LAUNCH cycle.
    assign wd_expired = (wd_cnt == WDW'(TIMEOUT_CYCLES - 2));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sel       <= '0;
            unit_a_id <= '0;
            unit_b_id <= '0;
            status    <= MATRIX_OP_STATUS_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        sel       <= cmd_op[SW-1:0];
                        unit_a_id <= cmd_a_id;
                        unit_b_id <= cmd_b_id;
                        if (op_bad) begin
                            status <= MATRIX_OP_STATUS_ERR_FORMAT;
                            state  <= S_COMPLETE;
                        end else begin
                            status <= MATRIX_OP_STATUS_BUSY;
                            state  <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: state <= S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (wd_expired) begin
                        status <= MATRIX_OP_STATUS_ERR_INTERNAL;
                        state  <= S_COMPLETE;
                    end else if (unit_busy[sel]) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (wd_expired) begin
                        status <= MATRIX_OP_STATUS_ERR_INTERNAL;
                        state  <= S_COMPLETE;
                    end else if (!unit_busy[sel]) begin
                        status <= unit_status[sel];
                        state  <= S_COMPLETE;
                    end
                end
                S_COMPLETE: state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    // Only the selected unit reaches the shared ports; everything else reads as zero.
    always_comb begin
        unit_start        = '0;
        unit_write_ready  = '0;
        unit_writer_ready = '0;
        unit_write_done   = '0;
        read_addr         = '0;
        write_request     = 1'b0;
        data_valid        = 1'b0;
        matrix_id         = '0;
        actual_rows       = '0;
        actual_cols       = '0;
        data_in           = '0;
        matrix_name       = '0;
        for (int i = 0; i < NUM_UNITS; i++)
            unit_start[i] = (state == S_LAUNCH) && (sel == SW'(i));
        if (active) begin
            read_addr              = unit_read_addr[sel];
            write_request          = unit_write_request[sel];
            data_valid             = unit_data_valid[sel];
            matrix_id              = unit_matrix_id[sel];
            actual_rows            = unit_actual_rows[sel];
            actual_cols            = unit_actual_cols[sel];
            data_in                = unit_data_in[sel];
            matrix_name            = unit_matrix_name[sel];
            unit_write_ready[sel]  = write_ready;
            unit_writer_ready[sel] = writer_ready;
            unit_write_done[sel]   = write_done;
        end
    end

endmodule
